dual_core_dispatcher: RTL and testbench

Job scheduler in front of the two compute cores of the dual-core chip. It buffers incoming tile-job descriptors in a FIFO and dispatches each job to whichever core is idle, using round-robin when both are idle. It tracks per-core busy state through a start/done handshake and counts completed jobs. It runs in a single clock domain; each core's instruction sequencer consumes the start pulse and job descriptor this block produces.

---
 rtl/dual_core_dispatcher_if.sv | 31 +++
 rtl/dual_core_dispatcher.sv | 121 ++++++++++++
 tb/tb_dual_core_dispatcher.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dual_core_dispatcher_if.sv
// Bus between the job source / two compute cores and the dual-core dispatcher.
// The dispatcher uses the slave modport; the job source and core models use master.
interface dual_core_dispatcher_if #(
    parameter int JOB_W = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    localparam int FCNT_W = $clog2(DEPTH) + 1;

    logic                job_valid;
    logic [JOB_W-1:0]    job_data;
    logic                job_ready;
    logic                flush;
    logic [1:0]          core_start;
    logic [2*JOB_W-1:0]  core_job;
    logic [1:0]          core_done;
    logic [1:0]          busy;
    logic [FCNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]    done_count;
    logic                all_idle;

    modport master (
        output job_valid, job_data, flush, core_done,
        input  job_ready, core_start, core_job, busy, fifo_count, done_count, all_idle
    );

    modport slave (
        input  job_valid, job_data, flush, core_done,
        output job_ready, core_start, core_job, busy, fifo_count, done_count, all_idle
    );
endinterface

// File: rtl/dual_core_dispatcher.sv
// Buffers tile-job descriptors in a FIFO and hands each one to an idle compute core,
// alternating between the cores when both are idle; counts completed jobs.
module dual_core_dispatcher #(
    parameter int JOB_W = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    dual_core_dispatcher_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, BUSY} core_state_t;

    core_state_t       state_q [2];
    core_state_t       state_d [2];
    logic [JOB_W-1:0]  mem     [DEPTH];
    logic [JOB_W-1:0]  job_q   [2];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] count;
    logic [CNT_W-1:0]  done_q;
    logic              rr;
    logic              ready;
    logic              fifo_empty;
    logic              push;
    logic              grant_valid;
    logic              grant_core;
    logic [1:0]        idle;
    logic [1:0]        done_accept;

    // Dispatch decision from registered state only; a flush edge blocks both push and grant.
    always_comb begin
        idle[0]     = (state_q[0] == IDLE);
        idle[1]     = (state_q[1] == IDLE);
        fifo_empty  = (count == '0);
        ready       = (count != FCNT_W'(DEPTH));
        push        = bus.job_valid && ready && !bus.flush;
        grant_valid = !bus.flush && !fifo_empty && (idle != 2'b00);
        grant_core  = (idle == 2'b11) ? rr : ~idle[0];
    end

    // Per-core next state; done pulses only count while the core is BUSY.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]     = state_q[i];
            done_accept[i] = 1'b0;
            case (state_q[i])
                IDLE:  if (grant_valid && (int'(grant_core) == i)) state_d[i] = START;
                START: state_d[i] = BUSY;
                BUSY: begin
                    if (bus.core_done[i]) begin
                        done_accept[i] = 1'b1;
                        state_d[i]     = IDLE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q[0] <= IDLE;
            state_q[1] <= IDLE;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // Full and empty are told apart by count, so the pointers simply wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)        wr_ptr <= wr_ptr + 1'b1;
            if (grant_valid) rd_ptr <= rd_ptr + 1'b1;
            count <= count + FCNT_W'(push) - FCNT_W'(grant_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.job_data;
    end

    // The rr pointer only moves when both cores were idle at the grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            job_q[0] <= '0;
            job_q[1] <= '0;
            rr       <= 1'b0;
            done_q   <= '0;
        end else begin
            if (grant_valid) begin
                job_q[grant_core] <= mem[rd_ptr];
                if (idle == 2'b11) rr <= ~rr;
            end
            done_q <= done_q + CNT_W'(done_accept[0]) + CNT_W'(done_accept[1]);
        end
    end

    always_comb begin
        bus.job_ready     = ready;
        bus.core_start[0] = (state_q[0] == START);
        bus.core_start[1] = (state_q[1] == START);
        bus.busy          = ~idle;
        bus.core_job      = {job_q[1], job_q[0]};
        bus.fifo_count    = count;
        bus.done_count    = done_q;
        bus.all_idle      = fifo_empty && (idle == 2'b11);
    end
endmodule

// File: tb/tb_dual_core_dispatcher.sv
// Directed self-checking bench for dual_core_dispatcher: round-robin, FIFO full,
// simultaneous done, flush and asynchronous reset, with hand-computed expectations.
module tb_dual_core_dispatcher;
    localparam int JOB_W = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fail;

    dual_core_dispatcher_if #(.JOB_W(JOB_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    dual_core_dispatcher #(.JOB_W(JOB_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [JOB_W-1:0] data,
                                 input logic fl, input logic [1:0] done);
        bus.job_valid = valid;
        bus.job_data  = data;
        bus.flush     = fl;
        bus.core_done = done;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 2'b00);

        // 1. reset then idle
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy_low", 32'(bus.busy), 32'h0);
        checkOutput("rst_job_low", bus.core_job, 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("idle_ready", 32'(bus.job_ready), 32'h1);
        checkOutput("idle_busy", 32'(bus.busy), 32'h0);
        checkOutput("idle_fcnt", 32'(bus.fifo_count), 32'h0);
        checkOutput("idle_dcnt", 32'(bus.done_count), 32'h0);
        checkOutput("idle_all", 32'(bus.all_idle), 32'h1);
        checkOutput("idle_start", 32'(bus.core_start), 32'h0);

        // 2. round-robin with both cores idle
        applyStimulus(1'b1, 16'h0011, 1'b0, 2'b00);
        tick();
        checkOutput("rr_first_fcnt", 32'(bus.fifo_count), 32'h1);
        checkOutput("rr_first_nostart", 32'(bus.core_start), 32'h0);
        applyStimulus(1'b1, 16'h0022, 1'b0, 2'b00);
        tick();
        checkOutput("rr_c0_start", 32'(bus.core_start), 32'h1);
        checkOutput("rr_c0_job", 32'(bus.core_job[15:0]), 32'h0011);
        checkOutput("rr_c0_fcnt", 32'(bus.fifo_count), 32'h1);
        applyStimulus(1'b1, 16'h0033, 1'b0, 2'b00);
        tick();
        checkOutput("rr_c1_start", 32'(bus.core_start), 32'h2);
        checkOutput("rr_c1_job", 32'(bus.core_job[31:16]), 32'h0022);
        checkOutput("rr_c1_busy", 32'(bus.busy), 32'h3);
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        tick();
        checkOutput("rr_wait_fcnt", 32'(bus.fifo_count), 32'h1);
        checkOutput("rr_wait_start", 32'(bus.core_start), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, 2'b10);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        checkOutput("rr_done1_busy", 32'(bus.busy), 32'h1);
        checkOutput("rr_done1_dcnt", 32'(bus.done_count), 32'h1);
        tick();
        checkOutput("rr_regrant_start", 32'(bus.core_start), 32'h2);
        checkOutput("rr_regrant_job", 32'(bus.core_job[31:16]), 32'h0033);
        checkOutput("rr_regrant_fcnt", 32'(bus.fifo_count), 32'h0);
        tick();
        checkOutput("rr_both_busy", 32'(bus.busy), 32'h3);

        // release both, then a both-idle grant goes to core1 (rr now points there)
        applyStimulus(1'b0, '0, 1'b0, 2'b11);
        tick();
        checkOutput("rel_dcnt", 32'(bus.done_count), 32'h3);
        checkOutput("rel_all_idle", 32'(bus.all_idle), 32'h1);
        applyStimulus(1'b1, 16'h00A1, 1'b0, 2'b00);
        tick();
        applyStimulus(1'b1, 16'h00A2, 1'b0, 2'b00);
        tick();
        checkOutput("rr2_c1_start", 32'(bus.core_start), 32'h2);
        checkOutput("rr2_c1_job", 32'(bus.core_job[31:16]), 32'h00A1);
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        tick();
        checkOutput("rr2_c0_start", 32'(bus.core_start), 32'h1);
        checkOutput("rr2_c0_job", 32'(bus.core_job[15:0]), 32'h00A2);
        checkOutput("rr2_fcnt", 32'(bus.fifo_count), 32'h0);
        tick();
        checkOutput("rr2_busy", 32'(bus.busy), 32'h3);

        // 3. FIFO full while both cores stay busy
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'(16'h0100 + i), 1'b0, 2'b00);
            tick();
            checkOutput("full_fcnt", 32'(bus.fifo_count), (i < 8) ? 32'(i + 1) : 32'd8);
            checkOutput("full_ready", 32'(bus.job_ready), (i < 7) ? 32'h1 : 32'h0);
        end
        applyStimulus(1'b0, '0, 1'b0, 2'b00);

        // 4. simultaneous done, then core0 first by rr, then core1
        applyStimulus(1'b0, '0, 1'b0, 2'b11);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        checkOutput("sim_dcnt", 32'(bus.done_count), 32'h5);
        checkOutput("sim_busy", 32'(bus.busy), 32'h0);
        checkOutput("sim_fcnt", 32'(bus.fifo_count), 32'h8);
        checkOutput("sim_ready", 32'(bus.job_ready), 32'h0);
        tick();
        checkOutput("sim_c0_start", 32'(bus.core_start), 32'h1);
        checkOutput("sim_c0_job", 32'(bus.core_job[15:0]), 32'h0100);
        checkOutput("sim_c0_fcnt", 32'(bus.fifo_count), 32'h7);
        checkOutput("sim_c0_ready", 32'(bus.job_ready), 32'h1);
        tick();
        checkOutput("sim_c1_start", 32'(bus.core_start), 32'h2);
        checkOutput("sim_c1_job", 32'(bus.core_job[31:16]), 32'h0101);
        checkOutput("sim_c1_fcnt", 32'(bus.fifo_count), 32'h6);
        tick();
        checkOutput("sim_settle_start", 32'(bus.core_start), 32'h0);

        // 5. flush mid-run: drain core1 twice so 4 jobs remain queued
        applyStimulus(1'b0, '0, 1'b0, 2'b10);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        tick();
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b10);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        tick();
        checkOutput("fl_pre_fcnt", 32'(bus.fifo_count), 32'h4);
        checkOutput("fl_pre_job", 32'(bus.core_job[31:16]), 32'h0103);
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 2'b00);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        checkOutput("fl_fcnt", 32'(bus.fifo_count), 32'h0);
        checkOutput("fl_busy", 32'(bus.busy), 32'h3);
        checkOutput("fl_nostart", 32'(bus.core_start), 32'h0);
        checkOutput("fl_jobs_held", bus.core_job, 32'h0103_0100);
        tick();
        checkOutput("fl_dropped_fcnt", 32'(bus.fifo_count), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, 2'b01);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        checkOutput("fl_c0_busy", 32'(bus.busy), 32'h2);
        checkOutput("fl_c0_dcnt", 32'(bus.done_count), 32'h8);
        checkOutput("fl_not_idle", 32'(bus.all_idle), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, 2'b10);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        checkOutput("fl_all_idle", 32'(bus.all_idle), 32'h1);
        checkOutput("fl_dcnt", 32'(bus.done_count), 32'h9);

        // 6. asynchronous reset while both cores are busy
        applyStimulus(1'b1, 16'h00C0, 1'b0, 2'b00);
        tick();
        applyStimulus(1'b1, 16'h00C1, 1'b0, 2'b00);
        tick();
        applyStimulus(1'b1, 16'h00C2, 1'b0, 2'b00);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        tick();
        checkOutput("ar_pre_busy", 32'(bus.busy), 32'h3);
        checkOutput("ar_pre_fcnt", 32'(bus.fifo_count), 32'h1);
        checkOutput("ar_pre_jobs", bus.core_job, 32'h00C0_00C1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("ar_busy", 32'(bus.busy), 32'h0);
        checkOutput("ar_start", 32'(bus.core_start), 32'h0);
        checkOutput("ar_dcnt", 32'(bus.done_count), 32'h0);
        checkOutput("ar_fcnt", 32'(bus.fifo_count), 32'h0);
        checkOutput("ar_jobs", bus.core_job, 32'h0);
        checkOutput("ar_all_idle", 32'(bus.all_idle), 32'h1);
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 16'h00D0, 1'b0, 2'b00);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 2'b00);
        tick();
        checkOutput("post_rst_start", 32'(bus.core_start), 32'h1);
        checkOutput("post_rst_job", 32'(bus.core_job[15:0]), 32'h00D0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
